// File: rtl/rv32_pkg.sv
// Shared RV32I constants and types for the fetch stage: NOP encoding,
// fetch exception codes and the instruction-queue entry layout.
package rv32_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      EXC_NONE           = 2'd0,
      EXC_IADDR_MISALIGN = 2'd1,
      EXC_IACCESS        = 2'd2
   } exc_e;

   typedef struct packed {
      exc_e            exc;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with synchronous clear and same-cycle push/pop.
// The caller never pushes into a full FIFO without popping in the same cycle.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: nothing is read while count is zero.
   always_ff @(posedge clk) begin
      if (push && !clr) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: credit-limited imem requests, PC tags for
// in-flight beats, and an instruction queue to ID. Optional FETCH_EXC_EN.
module if_fetch_unit
   import rv32_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   input  logic            flush,
   output logic            fetch_stall,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic            id_valid,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [1:0]      id_exc,
   input  logic            id_ready
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned SW = CW + 1;

   logic [CW-1:0]   occ;
   logic [CW-1:0]   live;
   logic [CW-1:0]   drop;
   logic [SW-1:0]   in_use;
   logic            q_empty;
   logic            t_empty;
   fetch_entry_t    q_head;
   fetch_entry_t    q_push_data;
   logic [XLEN-1:0] tag_head;
   logic            pop;
   logic            credit_ok;
   logic            accept;
   logic            rsp_keep;
   logic            q_push;
   logic            misaligned;
   logic            mis_enq;

   assign pop       = !q_empty && id_ready;
   assign in_use    = SW'(occ) + SW'(live) + SW'(drop) - SW'(pop);
   assign credit_ok = !rst && !flush && (in_use < SW'(DEPTH));

`ifdef FETCH_EXC_EN
   // Misaligned PCs bypass memory, but only once no live beat is pending so
   // queue order still matches PC order.
   assign misaligned = (pc[1:0] != 2'b00);
   assign mis_enq    = credit_ok && misaligned && (live == '0);
`else
   logic unused_ok;
   assign misaligned = 1'b0;
   assign mis_enq    = 1'b0;
   assign unused_ok  = ^{imem_rsp_err, q_head.exc, t_empty};
`endif

   assign imem_req_valid = credit_ok && !misaligned;
   assign imem_req_addr  = {pc[XLEN-1:2], 2'b00};
   assign accept         = imem_req_valid && imem_req_ready;
   assign fetch_stall    = !(accept || mis_enq);
   assign rsp_keep       = imem_rsp_valid && (drop == '0) && !flush;
   assign q_push         = rsp_keep || mis_enq;

   always_comb begin
      q_push_data       = '0;
      q_push_data.pc    = tag_head;
      q_push_data.instr = imem_rsp_data;
      q_push_data.exc   = EXC_NONE;
`ifdef FETCH_EXC_EN
      if (mis_enq) begin
         q_push_data.pc    = pc;
         q_push_data.instr = NOP_INSTR;
         q_push_data.exc   = EXC_IADDR_MISALIGN;
      end else if (imem_rsp_err) begin
         q_push_data.instr = NOP_INSTR;
         q_push_data.exc   = EXC_IACCESS;
      end
`endif
   end

   // On flush every live beat becomes a drop, less any beat landing this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop <= '0;
      end else if (flush) begin
         drop <= drop + live - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && (drop != '0)) begin
         drop <= drop - CW'(1);
      end
   end

   fetch_fifo #(
      .WIDTH(XLEN),
      .DEPTH(DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .push      (accept),
      .push_data (pc),
      .pop       (rsp_keep),
      .head      (tag_head),
      .empty     (t_empty),
      .count     (live)
   );

   fetch_fifo #(
      .WIDTH($bits(fetch_entry_t)),
      .DEPTH(DEPTH)
   ) u_instr_queue (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (pop),
      .head      (q_head),
      .empty     (q_empty),
      .count     (occ)
   );

   assign id_valid = !q_empty;
   assign id_instr = q_empty ? NOP_INSTR : q_head.instr;
   assign id_pc    = q_empty ? '0 : q_head.pc;
`ifdef FETCH_EXC_EN
   assign id_exc   = q_empty ? EXC_NONE : q_head.exc;
`else
   assign id_exc   = '0;
`endif

`ifndef SYNTHESIS
   a_no_orphan_rsp : assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> ((live != '0) || (drop != '0)));
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table plus hand-written
// flush and exception sequences against a variable-latency in-order memory.
module tb_if_fetch_unit;
   import rv32_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc = '0;
   logic        flush;
   logic        fetch_stall;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        imem_rsp_err = 1'b0;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [1:0]  id_exc;
   logic        id_ready;

   logic [31:0] flush_pc;
   int unsigned lat;
   logic [31:0] err_addr;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   int unsigned step_no = 0;

   if_fetch_unit #(.DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc             (pc),
      .flush          (flush),
      .fetch_stall    (fetch_stall),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_exc         (id_exc),
      .id_ready       (id_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5C3_0000;
   endfunction

   // DUT outputs captured mid-cycle for the PC and memory models
   logic        n_rv, n_st, n_rsp, n_rdy;
   logic [31:0] n_addr;
   int unsigned n_lat;
   always @(negedge clk) begin
      n_rv   = imem_req_valid;
      n_addr = imem_req_addr;
      n_st   = fetch_stall;
      n_rsp  = imem_rsp_valid;
      n_rdy  = imem_req_ready;
      n_lat  = lat;
   end

   // Program counter: flush target, hold on stall, otherwise +4
   logic        p_rst, p_fl, p_st;
   logic [31:0] p_fp;
   always @(posedge clk) begin
      p_rst = rst; p_fl = flush; p_fp = flush_pc; p_st = n_st;
      #1;
      if (p_rst)      pc = '0;
      else if (p_fl)  pc = p_fp;
      else if (!p_st) pc = pc + 32'd4;
   end

   // In-order memory: a request accepted at edge e is presented after edge e+lat-1
   typedef struct { logic [31:0] addr; int unsigned due; } beat_t;
   beat_t       mq[$];
   int unsigned edge_cnt = 0;
   logic        m_rst, m_req, m_pres;
   logic [31:0] m_addr;
   int unsigned m_lat;
   always @(posedge clk) begin
      m_rst = rst; m_req = n_rv && n_rdy; m_addr = n_addr; m_lat = n_lat; m_pres = n_rsp;
      edge_cnt++;
      #1;
      if (m_rst) begin
         mq.delete();
      end else begin
         if (m_pres && mq.size() > 0) void'(mq.pop_front());
         if (m_req) mq.push_back('{addr: m_addr, due: edge_cnt + m_lat - 1});
      end
      if (mq.size() > 0 && mq[0].due <= edge_cnt) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq[0].addr);
         imem_rsp_err   = (mq[0].addr == err_addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         imem_rsp_err   = 1'b0;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s step %0d: got %h, expected %h", nm, step_no, act, exp);
   endtask

   task automatic step(input logic r, f, input logic [31:0] fp, input logic rd, ir,
                       input int unsigned lt, input logic e_rv, input logic [31:0] e_addr,
                       input logic e_st, e_idv, input logic [31:0] e_pc, e_instr,
                       input logic [1:0] e_exc);
      rst = r; flush = f; flush_pc = fp; imem_req_ready = rd; id_ready = ir; lat = lt;
      @(negedge clk);
      check("req_valid", 32'(imem_req_valid), 32'(e_rv));
      if (e_rv) check("req_addr", imem_req_addr, e_addr);
      check("fetch_stall", 32'(fetch_stall), 32'(e_st));
      check("id_valid", 32'(id_valid), 32'(e_idv));
      check("id_pc", id_pc, e_pc);
      check("id_instr", id_instr, e_instr);
      check("id_exc", 32'(id_exc), 32'(e_exc));
      @(posedge clk);
      #1;
      step_no++;
   endtask

   typedef struct {
      logic r, f; logic [31:0] fp; logic rd, ir; int unsigned lt;
      logic e_rv; logic [31:0] e_addr; logic e_st, e_idv; logic [31:0] e_pc;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic r, f, input logic [31:0] fp, input logic rd, ir,
                      input int unsigned lt, input logic e_rv, input logic [31:0] e_addr,
                      input logic e_st, e_idv, input logic [31:0] e_pc);
      tbl.push_back('{r, f, fp, rd, ir, lt, e_rv, e_addr, e_st, e_idv, e_pc});
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; flush_pc = '0; imem_req_ready = 1'b1;
      id_ready = 1'b1; lat = 1; err_addr = '1;

      // reset, then 1-cycle streaming from pc 0 with a 3-cycle ready=0 gap
      add(1,0,0,     1,1,1, 0,0,     1,0,0);
      add(0,0,0,     1,1,1, 1,32'h00,0,0,0);
      add(0,0,0,     1,1,1, 1,32'h04,0,0,0);
      add(0,0,0,     1,1,1, 1,32'h08,0,1,32'h00);
      add(0,0,0,     1,1,1, 1,32'h0C,0,1,32'h04);
      add(0,0,0,     1,1,1, 1,32'h10,0,1,32'h08);
      add(0,0,0,     1,1,1, 1,32'h14,0,1,32'h0C);
      add(0,0,0,     0,1,1, 1,32'h18,1,1,32'h10);
      add(0,0,0,     0,1,1, 1,32'h18,1,1,32'h14);
      add(0,0,0,     0,1,1, 1,32'h18,1,0,0);
      add(0,0,0,     1,1,1, 1,32'h18,0,0,0);
      add(0,0,0,     1,1,1, 1,32'h1C,0,0,0);
      add(0,0,0,     1,1,1, 1,32'h20,0,1,32'h18);
      add(0,0,0,     1,1,1, 1,32'h24,0,1,32'h1C);
      // redirect to 0x10, ID back-pressure with two entries queued, release
      add(1,0,0,     1,1,1, 0,0,     1,0,0);
      add(0,1,32'h10,1,0,1, 0,0,     1,0,0);
      add(0,0,0,     1,0,1, 1,32'h10,0,0,0);
      add(0,0,0,     1,0,1, 1,32'h14,0,0,0);
      add(0,0,0,     1,0,1, 0,0,     1,1,32'h10);
      add(0,0,0,     1,0,1, 0,0,     1,1,32'h10);
      add(0,0,0,     1,0,1, 0,0,     1,1,32'h10);
      add(0,0,0,     1,1,1, 1,32'h18,0,1,32'h10);
      add(0,0,0,     1,1,1, 1,32'h1C,0,1,32'h14);
      add(0,0,0,     1,1,1, 1,32'h20,0,1,32'h18);
      // 3-cycle memory, flush to 0x100 with two requests in flight
      add(1,0,0,     1,1,3, 0,0,     1,0,0);
      add(0,0,0,     1,1,3, 1,32'h00,0,0,0);
      add(0,0,0,     1,1,3, 1,32'h04,0,0,0);
      add(0,1,32'h100,1,1,3,0,0,     1,0,0);
      add(0,0,0,     1,1,3, 0,0,     1,0,0);
      add(0,0,0,     1,1,3, 1,32'h100,0,0,0);
      add(0,0,0,     1,1,3, 1,32'h104,0,0,0);
      add(0,0,0,     1,1,3, 0,0,     1,0,0);
      add(0,0,0,     1,1,3, 0,0,     1,0,0);
      add(0,0,0,     1,1,3, 1,32'h108,0,1,32'h100);
      add(0,0,0,     1,1,3, 1,32'h10C,0,1,32'h104);

      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].f, tbl[i].fp, tbl[i].rd, tbl[i].ir, tbl[i].lt,
              tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_st, tbl[i].e_idv, tbl[i].e_pc,
              tbl[i].e_idv ? mem_word(tbl[i].e_pc) : NOP_INSTR, 2'd0);
      end

      // flush in the same cycle as a response beat (pc 4) and a pop (pc 0)
      step(1,0,0,      1,1,1, 0,0,      1,0,0,      NOP_INSTR,       2'd0);
      step(0,0,0,      1,1,1, 1,32'h00, 0,0,0,      NOP_INSTR,       2'd0);
      step(0,0,0,      1,1,1, 1,32'h04, 0,0,0,      NOP_INSTR,       2'd0);
      step(0,1,32'h40, 1,1,1, 0,0,      1,1,32'h00, mem_word(32'h0), 2'd0);
      step(0,0,0,      1,1,1, 1,32'h40, 0,0,0,      NOP_INSTR,       2'd0);
      step(0,0,0,      1,1,1, 1,32'h44, 0,0,0,      NOP_INSTR,       2'd0);
      step(0,0,0,      1,1,1, 1,32'h48, 0,1,32'h40, mem_word(32'h40),2'd0);

`ifdef FETCH_EXC_EN
      // misaligned pc 0x102 bypasses memory; error beat at pc 0x8
      err_addr = 32'h8;
      step(1,0,0,       1,1,1, 0,0,      1,0,0,       NOP_INSTR, EXC_NONE);
      step(0,1,32'h102, 1,1,1, 0,0,      1,0,0,       NOP_INSTR, EXC_NONE);
      step(0,0,0,       1,1,1, 0,0,      0,0,0,       NOP_INSTR, EXC_NONE);
      step(0,1,32'h8,   1,1,1, 0,0,      1,1,32'h102, NOP_INSTR, EXC_IADDR_MISALIGN);
      step(0,0,0,       1,1,1, 1,32'h08, 0,0,0,       NOP_INSTR, EXC_NONE);
      step(0,0,0,       1,1,1, 1,32'h0C, 0,0,0,       NOP_INSTR, EXC_NONE);
      step(0,0,0,       1,1,1, 1,32'h10, 0,1,32'h8,   NOP_INSTR, EXC_IACCESS);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage sitting between the program counter and the ID stage of the 5-stage RV32I pipeline. Takes the current PC, issues word requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses, and buffers returned instructions with their PCs in a small queue presented to ID. Applies back-pressure to the PC via `fetch_stall` and discards wrong-path responses on an EX-stage redirect.

## Interface
- `DEPTH`, 2: queue entries and maximum requests in flight; power of two, ≥2.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  32  current PC from the program counter.
- `flush`  in  1  EX redirect (branch taken or flush); PC changes at the next edge.
- `fetch_stall`  out  1  hold PC; OR'd with the ID stall at the PC input.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_addr`  out  32  word address, `{pc[31:2],2'b00}`.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  response beat, strictly in request order.
- `imem_rsp_data`  in  32  instruction word.
- `imem_rsp_err`  in  1  access fault for this beat.
- `id_valid`  out  1  queue head valid.
- `id_instr`  out  32  head instruction; `NOP_INSTR` when empty.
- `id_pc`  out  32  head PC; 0 when empty.
- `id_exc`  out  2  head exception code (only with `FETCH_EXC_EN`).
- `id_ready`  in  1  ID consumes head this cycle.

## Operation
- State: `occ` (queue occupancy, 0..DEPTH), `live` (in-flight, to be kept), `drop` (in-flight, to be discarded), PC-tag FIFO of in-flight live requests.
- Credit rule: `imem_req_valid = !flush && (occ + live + drop - pop) < DEPTH`, where `pop = id_valid && id_ready`.
- Accept (`imem_req_valid && imem_req_ready`): `live++`, push `pc` into the tag FIFO.
- `fetch_stall = !(imem_req_valid && imem_req_ready)`; during `flush` the PC flush priority overrides it.
- Response: if `drop>0`, `drop--` and discard the beat; otherwise `live--`, pop tag, push `{data, tag, exc}` into the queue.
- Pop on `id_valid && id_ready`; the head advances at the next edge.
- `flush`: queue cleared, `drop += live` (including any request accepted or beat arriving that same cycle, whose data is discarded), `live = 0`, tag FIFO cleared, no request issued that cycle.
- Overflow is impossible by the credit rule. Assert (simulation only) that a response never arrives with `live+drop==0`.

## Timing
- Reset: `imem_req_valid=0`, `fetch_stall=1`, `id_valid=0`, `id_instr=NOP_INSTR`, `id_pc=0`, `id_exc=0`; all counters and FIFOs empty. Reset mid-transaction abandons in-flight responses. Memory is reset by the same `rst`.
- The first request is issued in the first cycle after reset deassertion.
- Latency: response in cycle t → `id_valid` in t+1. There is no response-to-ID bypass.
- With 1-cycle memory and `id_ready=1`: request t, response t+1, ID t+2; sustained 1 instr/cycle at DEPTH=2.
- Same-cycle push and pop are both honoured; `occ` is unchanged.
- `flush` and `rst` take effect at the edge; `id_valid=0` in the cycle after `flush`.

## Configuration
- `FETCH_EXC_EN` defined:
  - `pc[1:0]!=0` issues no memory request. When the credit allows, it enqueues directly with `id_exc=EXC_IADDR_MISALIGN`, instr=`NOP_INSTR`, and deasserts `fetch_stall`.
  - `imem_rsp_err` sets `id_exc=EXC_IACCESS` and replaces instr with `NOP_INSTR`.
- Undefined: `pc[1:0]` is ignored, `imem_rsp_err` is ignored, and `id_exc` is tied to 0.

## Structure
- `rv32_pkg`: `NOP_INSTR` (32'h0000_0013), `EXC_NONE`/`EXC_IADDR_MISALIGN`/`EXC_IACCESS` 2-bit codes, `XLEN`=32.
- One sub-module, `fetch_fifo`: parametrised synchronous FIFO (width, DEPTH), with clear and same-cycle push/pop. It is instantiated twice, as the tag FIFO and as the instruction queue.

## Test plan
- 1-cycle memory, `id_ready=1`, PC from 0: IDs get pc 0,4,8,... with one instruction per cycle, starting 2 cycles after the first request.
- `imem_req_ready=0` for 3 cycles: `fetch_stall=1` for those cycles, no duplicate or lost PCs.
- `id_ready=0` with 2 entries queued: `imem_req_valid=0` and `fetch_stall=1`. Release: the head pc 0x10 is consumed next, in order.
- 3-cycle memory, `flush` with 2 in flight and pc_flush=0x100: both stale beats are dropped, and the first ID instruction has `id_pc=0x100`.
- `flush` on the same cycle a response arrives and a pop occurs: the beat is discarded and the queue is empty next cycle.
- `FETCH_EXC_EN`: pc=0x102 gives `id_exc=EXC_IADDR_MISALIGN` with no memory request. Err beat at pc 0x8 gives `EXC_IACCESS` with instr `NOP_INSTR`.
